em_project_pll_reconfig_ctrl: RTL and testbench

//  Sequences run-time retuning of the reconfigurable 50 MHz-ref PLL (3 outputs) through the PLL

---
 rtl/em_project_pll_reconfig_pkg.sv | 50 +++++
 rtl/em_project_pll_mgmt_wr.sv | 60 ++++++
 rtl/em_project_pll_reconfig_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_em_project_pll_reconfig_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/em_project_pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration controller: management-port
// register addresses, controller state encoding, error codes and the payload
// packing helpers for the C-counter and phase-shift registers.
package em_project_pll_reconfig_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ERR_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_START = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_C_CNT = 6'h05;
    localparam logic [ADDR_W-1:0] ADDR_PHASE = 6'h06;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_BAD_SEL = 2'd1;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_WR_MODE, ST_WR_CNT,
        ST_WR_PHASE, ST_WR_START, ST_SETTLE, ST_WAIT_LOCK
    } state_e;

    // Latched C-counter update request
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             odd;
        logic             bypass;
        logic [7:0]       hi;
        logic [7:0]       lo;
    } c_cnt_req_t;

    // Latched phase-shift request
    typedef struct packed {
        logic             up;
        logic [SEL_W-1:0] cnt;
        logic [15:0]      steps;
    } phase_req_t;

    function automatic logic [DATA_W-1:0] pack_c_cnt(input c_cnt_req_t r);
        return {9'b0, r.sel, r.odd, r.bypass, r.hi, r.lo};
    endfunction

    function automatic logic [DATA_W-1:0] pack_phase(input phase_req_t p);
        return {10'b0, p.up, p.cnt, p.steps};
    endfunction

endpackage

// File: rtl/em_project_pll_mgmt_wr.sv
// Single Avalon-MM write engine for the PLL reconfig management port.
//   clk, reset_n          : clock, synchronous active-low reset
//   go, addr, data        : write request; sampled only while no write is active
//   ack_c                 : high in the cycle the core accepts the write
//   mgmt_address/_write/_writedata, mgmt_waitrequest : Avalon-MM master side
// A new write can only load while mgmt_write is low, so the cycle after every
// acceptance is always an idle cycle on the bus.
module em_project_pll_mgmt_wr
    import em_project_pll_reconfig_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              ack_c,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic              mgmt_write,
    output logic [DATA_W-1:0] mgmt_writedata,
    input  logic              mgmt_waitrequest
);

    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Hold address/data stable while stalled; drop the strobe after acceptance
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ack_c   = write_q && !mgmt_waitrequest;
        if (write_q) begin
            if (!mgmt_waitrequest) begin
                write_d = 1'b0;
            end
        end else if (go) begin
            write_d = 1'b1;
            addr_d  = addr;
            data_d  = data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mgmt_write     = write_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;

endmodule

// File: rtl/em_project_pll_reconfig_ctrl.sv
// Sequences run-time retuning of the reconfigurable PLL through the reconfig
// core's management port: mode write, C-counter write, optional phase write,
// start write, settle delay, then wait for relock with timeout.
//   clk, reset_n                    : clock, synchronous active-low reset
//   req_valid/req_ready, req_*      : one C-counter update request at a time
//   mgmt_*                          : Avalon-MM master to the reconfig core
//   pll_locked                      : asynchronous lock, synchronised here
//   busy, done, err, err_code       : status (done/err are 1-cycle pulses)
// Optional feature macro PLL_RECONFIG_PHASE_EN adds req_phase_* ports and the
// phase-shift register write (skipped when the step count is zero).
module em_project_pll_reconfig_ctrl
    import em_project_pll_reconfig_pkg::*;
#(
    parameter int unsigned LOCK_SETTLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned NUM_CNT      = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_cnt_sel,
    input  logic [7:0]        req_hi,
    input  logic [7:0]        req_lo,
    input  logic              req_odd,
    input  logic              req_bypass,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic              mgmt_write,
    output logic [DATA_W-1:0] mgmt_writedata,
    input  logic              mgmt_waitrequest,
    input  logic              pll_locked,
`ifdef PLL_RECONFIG_PHASE_EN
    input  logic [15:0]       req_phase_steps,
    input  logic              req_phase_up,
    input  logic [SEL_W-1:0]  req_phase_cnt,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ERR_W-1:0]  err_code
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(LOCK_SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_e            state_q, state_d;
    c_cnt_req_t        req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_meta_q, locked_sync_q;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_code_q, err_code_d;
    logic              wr_go_c, wr_ack_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
`ifdef PLL_RECONFIG_PHASE_EN
    phase_req_t        ph_q, ph_d;
`endif

    em_project_pll_mgmt_wr u_mgmt_wr (
        .clk              (clk),
        .reset_n          (reset_n),
        .go               (wr_go_c),
        .addr             (wr_addr_c),
        .data             (wr_data_c),
        .ack_c            (wr_ack_c),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    // Next-state, write requests and registered status
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        wr_go_c    = 1'b0;
        wr_addr_c  = '0;
        wr_data_c  = '0;
`ifdef PLL_RECONFIG_PHASE_EN
        ph_d       = ph_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d = '{sel: req_cnt_sel, odd: req_odd, bypass: req_bypass,
                              hi: req_hi, lo: req_lo};
`ifdef PLL_RECONFIG_PHASE_EN
                    ph_d  = '{up: req_phase_up, cnt: req_phase_cnt, steps: req_phase_steps};
`endif
                    err_code_d = ERR_NONE;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (32'(req_q.sel) >= NUM_CNT) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_SEL;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WR_MODE;
                end
            end
            // go stays high through a write; the engine ignores it until idle
            ST_WR_MODE: begin
                wr_go_c   = 1'b1;
                wr_addr_c = ADDR_MODE;
                wr_data_c = '0;
                if (wr_ack_c) state_d = ST_WR_CNT;
            end
            ST_WR_CNT: begin
                wr_go_c   = 1'b1;
                wr_addr_c = ADDR_C_CNT;
                wr_data_c = pack_c_cnt(req_q);
`ifdef PLL_RECONFIG_PHASE_EN
                if (wr_ack_c) state_d = (ph_q.steps != '0) ? ST_WR_PHASE : ST_WR_START;
`else
                if (wr_ack_c) state_d = ST_WR_START;
`endif
            end
`ifdef PLL_RECONFIG_PHASE_EN
            ST_WR_PHASE: begin
                wr_go_c   = 1'b1;
                wr_addr_c = ADDR_PHASE;
                wr_data_c = pack_phase(ph_q);
                if (wr_ack_c) state_d = ST_WR_START;
            end
`endif
            ST_WR_START: begin
                wr_go_c   = 1'b1;
                wr_addr_c = ADDR_START;
                wr_data_c = DATA_W'(1);
                if (wr_ack_c) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            // Lock is not trusted until the PLL has had time to drop it
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Lock has priority over a timeout expiring in the same cycle
            ST_WAIT_LOCK: begin
                if (locked_sync_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            cnt_q         <= '0;
            locked_meta_q <= 1'b0;
            locked_sync_q <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
`ifdef PLL_RECONFIG_PHASE_EN
            ph_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            cnt_q         <= cnt_d;
            locked_meta_q <= pll_locked;
            locked_sync_q <= locked_meta_q;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
`ifdef PLL_RECONFIG_PHASE_EN
            ph_q          <= ph_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_em_project_pll_reconfig_ctrl.sv
// Self-checking bench for em_project_pll_reconfig_ctrl. A transaction-level
// model derives, per request, the expected write list and the cycle-by-cycle
// timeline (write windows, settle, relock/timeout) from the stall counts and the
// lock waveform the bench itself drives; every cycle of the transaction is
// compared against it. Directed cases pin the model with literal values.
module tb_em_project_pll_reconfig_ctrl;

    localparam int unsigned LOCK_SETTLE  = 16;
    localparam int unsigned LOCK_TIMEOUT = 100;
    localparam int unsigned NUM_CNT      = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_cnt_sel = '0;
    logic [7:0]  req_hi = '0;
    logic [7:0]  req_lo = '0;
    logic        req_odd = 1'b0;
    logic        req_bypass = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;
`ifdef PLL_RECONFIG_PHASE_EN
    logic [15:0] req_phase_steps = '0;
    logic        req_phase_up = 1'b0;
    logic [4:0]  req_phase_cnt = '0;
`endif

    always #5 clk = ~clk;

    em_project_pll_reconfig_ctrl #(
        .LOCK_SETTLE  (LOCK_SETTLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .NUM_CNT      (NUM_CNT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cnt_sel      (req_cnt_sel),
        .req_hi           (req_hi),
        .req_lo           (req_lo),
        .req_odd          (req_odd),
        .req_bypass       (req_bypass),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
`ifdef PLL_RECONFIG_PHASE_EN
        .req_phase_steps  (req_phase_steps),
        .req_phase_up     (req_phase_up),
        .req_phase_cnt    (req_phase_cnt),
`endif
        .busy             (busy),
        .done             (done),
        .err              (err),
        .err_code         (err_code)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int last_code = 0;
    int done_p, err_p, saw_phase = 0;
    logic [37:0] cap_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_cnt_word(input int sel, hi, lo, odd, byp);
        return 32'((sel << 18) + (odd << 17) + (byp << 16) + (hi << 8) + lo);
    endfunction

    task automatic randomize_req();
        req_cnt_sel = 5'($urandom_range(0, 31));
        req_hi      = 8'($urandom_range(0, 255));
        req_lo      = 8'($urandom_range(0, 255));
        req_odd     = 1'($urandom_range(0, 1));
        req_bypass  = 1'($urandom_range(0, 1));
`ifdef PLL_RECONFIG_PHASE_EN
        req_phase_steps = 16'($urandom_range(0, 65535));
        req_phase_up    = 1'($urandom_range(0, 1));
        req_phase_cnt   = 5'($urandom_range(0, 31));
`endif
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_err", 32'(err), 0);
            chk("idle_mgmt_write", 32'(mgmt_write), 0);
            chk("idle_req_ready", 32'(req_ready), 1);
            chk("idle_err_code", 32'(err_code), 32'(last_code));
            req_valid        = 1'b0;
            pll_locked       = 1'($urandom_range(0, 1));
            mgmt_waitrequest = 1'($urandom_range(0, 1));
        end
    endtask

    // lock_rel: lock rises at (WAIT_LOCK start - 2 + lock_rel); -1 = never.
    // rst_p: cycle after accept at which reset is asserted; -1 = none.
    task automatic run_txn(input int sel, hi, lo, odd, byp, ph_steps, ph_up, ph_cnt,
                           input int w0, w1, w2, w3, lock_rel, rst_p);
        int n, ew, endc, code, lock_rise, guard, iw;
        int waddr[4];
        logic [31:0] wdata[4];
        int wt[4];
        int start[4];
        bit ok;
        wt[0] = w0; wt[1] = w1; wt[2] = w2; wt[3] = w3;
        n = 0;
        if (sel < int'(NUM_CNT)) begin
            waddr[0] = 0; wdata[0] = 32'h0;
            waddr[1] = 5; wdata[1] = m_cnt_word(sel, hi, lo, odd, byp);
            n = 2;
`ifdef PLL_RECONFIG_PHASE_EN
            if (ph_steps != 0) begin
                waddr[n] = 6; wdata[n] = 32'((ph_up << 21) + (ph_cnt << 16) + ph_steps);
                n++;
            end
`endif
            waddr[n] = 2; wdata[n] = 32'h1;
            n++;
        end
        ew = 0;
        if (n == 0) begin
            ok = 1'b0; code = 1; endc = 1;
        end else begin
            start[0] = 2;
            for (int i = 1; i < n; i++) start[i] = start[i-1] + wt[i-1] + 2;
            ew = start[n-1] + wt[n-1] + 1 + int'(LOCK_SETTLE);
            ok = 1'b0; code = 2; endc = ew + int'(LOCK_TIMEOUT);
            for (int k = 0; k < int'(LOCK_TIMEOUT); k++) begin
                if (lock_rel >= 0 && (k - lock_rel) >= 0) begin
                    ok = 1'b1; code = 0; endc = ew + k + 1;
                    break;
                end
            end
        end
        lock_rise = ew - 2 + lock_rel;

        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            chk("ready_wait", 32'(req_ready), 1);
            return;
        end
        req_valid   = 1'b1;
        req_cnt_sel = 5'(sel);
        req_hi      = 8'(hi);
        req_lo      = 8'(lo);
        req_odd     = 1'(odd);
        req_bypass  = 1'(byp);
`ifdef PLL_RECONFIG_PHASE_EN
        req_phase_steps = 16'(ph_steps);
        req_phase_up    = 1'(ph_up);
        req_phase_cnt   = 5'(ph_cnt);
`endif
        cap_q.delete();
        done_p = -1;
        err_p  = -1;
        @(posedge clk);

        for (int p = 0; p <= endc; p++) begin
            @(negedge clk);
            if (done) done_p = p;
            if (err)  err_p  = p;
            chk("busy", 32'(busy), 32'(p < endc));
            chk("req_ready", 32'(req_ready), 32'(p >= endc));
            chk("done", 32'(done), 32'(p == endc && ok));
            chk("err", 32'(err), 32'(p == endc && !ok));
            chk("err_code", 32'(err_code), (p >= endc) ? 32'(code) : 32'h0);
            iw = -1;
            for (int i = 0; i < n; i++)
                if (p >= start[i] && p <= start[i] + wt[i]) iw = i;
            chk("mgmt_write", 32'(mgmt_write), 32'(iw >= 0));
            if (iw >= 0) begin
                chk("mgmt_address", 32'(mgmt_address), 32'(waddr[iw]));
                chk("mgmt_writedata", mgmt_writedata, wdata[iw]);
            end
            if (p == rst_p) begin
                reset_n          = 1'b0;
                mgmt_waitrequest = 1'b1;
                req_valid        = 1'b0;
                @(negedge clk);
                chk("rst_mgmt_write", 32'(mgmt_write), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_err", 32'(err), 0);
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_err_code", 32'(err_code), 0);
                reset_n          = 1'b1;
                mgmt_waitrequest = 1'b0;
                @(negedge clk);
                chk("rst_release_ready", 32'(req_ready), 1);
                chk("rst_release_done", 32'(done | err), 0);
                last_code = 0;
                return;
            end
            pll_locked = (p >= ew - 2) ? 1'(lock_rel >= 0 && p >= lock_rise)
                                       : 1'($urandom_range(0, 1));
            if (iw >= 0) mgmt_waitrequest = 1'(p < start[iw] + wt[iw]);
            else         mgmt_waitrequest = 1'($urandom_range(0, 1));
            randomize_req();
            req_valid = (p < endc) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (mgmt_write && !mgmt_waitrequest) begin
                cap_q.push_back({mgmt_address, mgmt_writedata});
                if (mgmt_address == 6'h06) saw_phase++;
            end
        end
        last_code = code;
    endtask

    initial begin
        int cnt5;
        logic [37:0] e;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_mgmt_write", 32'(mgmt_write), 0);
        chk("reset_mgmt_address", 32'(mgmt_address), 0);
        chk("reset_mgmt_writedata", mgmt_writedata, 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_err_code", 32'(err_code), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 1);

        // Basic retune: three writes in order, relock after settle
        run_txn(1, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, -1);
        chk("t1_nwrites", 32'(cap_q.size()), 3);
        if (cap_q.size() == 3) begin
            chk("t1_w0", 32'(cap_q[0] >> 32), 32'h00);
            chk("t1_w1_addr", 32'(cap_q[1] >> 32), 32'h05);
            chk("t1_w1_data", cap_q[1][31:0], 32'h0006_0302);
            chk("t1_w2", cap_q[2][31:0], 32'h1);
        end
        chk("t1_done_cycle", 32'(done_p), 31);
        chk("t1_err_code", 32'(err_code), 0);
        idle_cycles(2);

        // Long stall on the C-counter write
        run_txn(2, 8'h10, 8'h20, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, -1);
        cnt5 = 0;
        foreach (cap_q[i]) begin
            e = cap_q[i];
            if (e[37:32] == 6'h05) begin
                cnt5++;
                chk("t2_data", e[31:0], 32'h0009_1020);
            end
        end
        chk("t2_cnt_writes", 32'(cnt5), 1);
        idle_cycles(1);

        // Bad select
        run_txn(5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        chk("t3_err_cycle", 32'(err_p), 1);
        chk("t3_nwrites", 32'(cap_q.size()), 0);
        chk("t3_err_code", 32'(err_code), 1);
        idle_cycles(2);

        // Lock never returns
        run_txn(0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1);
        chk("t4_err_cycle", 32'(err_p), 123);
        chk("t4_err_code", 32'(err_code), 2);
        idle_cycles(2);

        // Lock arriving on the timeout cycle beats the timeout; one later loses
        run_txn(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 99, -1);
        chk("t7_done_cycle", 32'(done_p), 123);
        idle_cycles(1);
        run_txn(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 100, -1);
        chk("t7_err_cycle", 32'(err_p), 123);
        idle_cycles(1);

        // Reset while the start write is stalled
        run_txn(1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 9);
        idle_cycles(3);

`ifdef PLL_RECONFIG_PHASE_EN
        run_txn(0, 2, 2, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, -1);
        chk("t6_nwrites", 32'(cap_q.size()), 4);
        if (cap_q.size() == 4) begin
            chk("t6_phase_addr", 32'(cap_q[2] >> 32), 32'h06);
            chk("t6_phase_data", cap_q[2][31:0], 32'h0020_0004);
        end
        idle_cycles(1);
        run_txn(0, 2, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, -1);
        chk("t6_skip_nwrites", 32'(cap_q.size()), 3);
        idle_cycles(1);
`endif

        for (int t = 0; t < 40; t++) begin
            int sel, rel, steps;
            sel   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 31))
                                                : int'($urandom_range(0, 2));
            rel   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 104));
            steps = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 65535));
            run_txn(sel, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    steps, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rel, -1);
            idle_cycles(int'($urandom_range(0, 3)));
        end

`ifndef PLL_RECONFIG_PHASE_EN
        chk("no_phase_writes", 32'(saw_phase), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
